// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode/funct codes, FSM state encodings and hit-decode helpers
// for the sequential hazard controller and its match decoder.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWU    = 6'h27;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ADD    = 6'h20;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_JMP    = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;

  typedef struct packed {
    logic halt;
    logic load;
    logic jump;
  } hazard_hits_t;

  function automatic logic is_load_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LWU, OP_LBU, OP_LHU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    case (op)
      OP_R_TYPE, OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_jump(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_J) || (op == OP_JAL) ||
           ((op == OP_R_TYPE) && ((funct == FN_JR) || (funct == FN_JALR)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_match.sv
// Combinational hazard decode for the instruction in ID against the load in EX;
// shared with the forwarding unit tests.
module hazard_match
  import hazard_ctrl_pkg::*;
#(
  parameter int NB_REG = 5,
  parameter int NB_OP  = 6
) (
  input  logic [NB_OP-1:0]  if_id_op,
  input  logic [NB_OP-1:0]  if_id_funct,
  input  logic [NB_REG-1:0] if_id_rs,
  input  logic [NB_REG-1:0] if_id_rt,
  input  logic [NB_OP-1:0]  id_ex_op,
  input  logic [NB_REG-1:0] id_ex_rt,
  output hazard_hits_t      hits
);

  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign rs_match = (id_ex_rt == if_id_rs);
  assign rt_match = reads_rt(if_id_op) && (id_ex_rt == if_id_rt);

  always_comb begin
    hits      = '0;
    hits.halt = (if_id_op == OP_HALT);
    hits.load = is_load_op(id_ex_op) && (id_ex_rt != '0) && (rs_match || rt_match);
    hits.jump = is_jump(if_id_op, if_id_funct);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Sequential hazard control: holds load-use stalls and jump flushes for a
// configurable number of cycles, latches HALT, and counts stall/flush cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NB_REG      = 5,
  parameter int NB_OP       = 6,
  parameter int LOAD_STALLS = 1,
  parameter int JMP_BUBBLES = 1,
  parameter int NB_CNT      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB_OP-1:0]  i_if_id_op,
  input  logic [NB_OP-1:0]  i_if_id_funct,
  input  logic [NB_REG-1:0] i_if_id_rs,
  input  logic [NB_REG-1:0] i_if_id_rt,
  input  logic [NB_OP-1:0]  i_id_ex_op,
  input  logic [NB_REG-1:0] i_id_ex_rt,
  output logic              o_pc_stall,
  output logic              o_bubble,
  output logic              o_if_id_flush,
  output logic              o_halt,
  output logic [NB_CNT-1:0] o_stall_cnt
);

  // The detection cycle in RUN is already the first stall/flush cycle, so the
  // hold states are entered only for counts above one, preloaded with N-2.
  localparam logic       JMP_EN       = (JMP_BUBBLES > 0);
  localparam logic       LOAD_MULTI   = (LOAD_STALLS > 1);
  localparam logic       JMP_MULTI    = (JMP_BUBBLES > 1);
  localparam logic [2:0] LOAD_PRELOAD = LOAD_MULTI ? 3'(LOAD_STALLS - 2) : 3'd0;
  localparam logic [2:0] JMP_PRELOAD  = JMP_MULTI  ? 3'(JMP_BUBBLES - 2) : 3'd0;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nxt;
  logic [NB_CNT-1:0] stall_cnt;
  hazard_hits_t      hits;
  logic              in_run;
  logic              stall;
  logic              flush;
  logic              halt;

  hazard_match #(
    .NB_REG (NB_REG),
    .NB_OP  (NB_OP)
  ) u_match (
    .if_id_op    (i_if_id_op),
    .if_id_funct (i_if_id_funct),
    .if_id_rs    (i_if_id_rs),
    .if_id_rt    (i_if_id_rt),
    .id_ex_op    (i_id_ex_op),
    .id_ex_rt    (i_id_ex_rt),
    .hits        (hits)
  );

  assign in_run = (state == ST_RUN);
  assign stall  = (in_run & hits.load) | (state == ST_LOAD) | (state == ST_HALT);
  assign flush  = (in_run & hits.jump & JMP_EN) | (state == ST_JMP);
  assign halt   = (in_run & hits.halt) | (state == ST_HALT);

  // Reset masks the outputs in the same cycle so a stale state never leaks out.
  assign o_pc_stall    = ~i_reset & stall;
  assign o_bubble      = ~i_reset & stall;
  assign o_if_id_flush = ~i_reset & flush;
  assign o_halt        = ~i_reset & halt;
  assign o_stall_cnt   = stall_cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RUN: begin
        if (hits.halt) begin
          state_nxt = ST_HALT;
        end else if (hits.load) begin
          if (LOAD_MULTI) begin
            state_nxt = ST_LOAD;
            cnt_nxt   = LOAD_PRELOAD;
          end
        end else if (hits.jump && JMP_MULTI) begin
          state_nxt = ST_JMP;
          cnt_nxt   = JMP_PRELOAD;
        end
      end
      ST_LOAD, ST_JMP: begin
        if (cnt == 3'd0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_RUN;
      cnt       <= 3'd0;
      stall_cnt <= '0;
    end else if (i_enable) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((stall | flush) && (state != ST_HALT) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven scoreboard bench for hazard_ctrl, exercising three parameter
// sets side by side on shared ID/EX inputs.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct {
    logic       rst;
    logic       en;
    logic [5:0] xop;
    logic [4:0] xrt;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
  } stim_t;

  typedef struct {
    logic        chk;
    logic        sa, fa, ha;
    logic [15:0] ca;
    logic        sb, fb, hb;
    logic [15:0] cb;
    logic        cchk;
    logic [15:0] cc;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [5:0] if_id_op = OP_ADDI;
  logic [5:0] if_id_funct = 6'd0;
  logic [4:0] if_id_rs = 5'd1;
  logic [4:0] if_id_rt = 5'd2;
  logic [5:0] id_ex_op = OP_ADDI;
  logic [4:0] id_ex_rt = 5'd0;

  logic        a_stall, a_bub, a_flush, a_halt;
  logic [15:0] a_cnt;
  logic        b_stall, b_bub, b_flush, b_halt;
  logic [3:0]  b_cnt;
  logic        c_stall, c_bub, c_flush, c_halt;
  logic [15:0] c_cnt;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   row = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALLS(1), .JMP_BUBBLES(1), .NB_CNT(16)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_if_id_op(if_id_op), .i_if_id_funct(if_id_funct), .i_if_id_rs(if_id_rs),
    .i_if_id_rt(if_id_rt), .i_id_ex_op(id_ex_op), .i_id_ex_rt(id_ex_rt),
    .o_pc_stall(a_stall), .o_bubble(a_bub), .o_if_id_flush(a_flush),
    .o_halt(a_halt), .o_stall_cnt(a_cnt)
  );

  hazard_ctrl #(.LOAD_STALLS(3), .JMP_BUBBLES(2), .NB_CNT(4)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_if_id_op(if_id_op), .i_if_id_funct(if_id_funct), .i_if_id_rs(if_id_rs),
    .i_if_id_rt(if_id_rt), .i_id_ex_op(id_ex_op), .i_id_ex_rt(id_ex_rt),
    .o_pc_stall(b_stall), .o_bubble(b_bub), .o_if_id_flush(b_flush),
    .o_halt(b_halt), .o_stall_cnt(b_cnt)
  );

  hazard_ctrl #(.LOAD_STALLS(1), .JMP_BUBBLES(0), .NB_CNT(16)) dut_c (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_if_id_op(if_id_op), .i_if_id_funct(if_id_funct), .i_if_id_rs(if_id_rs),
    .i_if_id_rt(if_id_rt), .i_id_ex_op(id_ex_op), .i_id_ex_rt(id_ex_rt),
    .o_pc_stall(c_stall), .o_bubble(c_bub), .o_if_id_flush(c_flush),
    .o_halt(c_halt), .o_stall_cnt(c_cnt)
  );

  function automatic stim_t st(input logic rst, input logic en,
                               input logic [5:0] xop, input logic [4:0] xrt,
                               input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] rs, input logic [4:0] rt);
    stim_t s;
    s.rst = rst; s.en = en; s.xop = xop; s.xrt = xrt;
    s.op = op; s.fn = fn; s.rs = rs; s.rt = rt;
    return s;
  endfunction

  function automatic exp_t ex(input int sa, input int fa, input int ha, input int ca,
                              input int sb, input int fb, input int hb, input int cb);
    exp_t e;
    e.chk = 1'b1;
    e.sa = (sa != 0); e.fa = (fa != 0); e.ha = (ha != 0); e.ca = 16'(ca);
    e.sb = (sb != 0); e.fb = (fb != 0); e.hb = (hb != 0); e.cb = 16'(cb);
    e.cchk = 1'b0;
    e.cc = 16'd0;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL row%0d %s: got %0d, expected %0d", row, nm, act, want);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL row%0d scoreboard: got empty queue, expected an entry", row);
      return;
    end
    e = sb_q.pop_front();
    if (e.chk) begin
      cmp("a.pc_stall", {15'd0, a_stall}, {15'd0, e.sa});
      cmp("a.bubble",   {15'd0, a_bub},   {15'd0, e.sa});
      cmp("a.flush",    {15'd0, a_flush}, {15'd0, e.fa});
      cmp("a.halt",     {15'd0, a_halt},  {15'd0, e.ha});
      cmp("a.cnt",      a_cnt,            e.ca);
      cmp("b.pc_stall", {15'd0, b_stall}, {15'd0, e.sb});
      cmp("b.bubble",   {15'd0, b_bub},   {15'd0, e.sb});
      cmp("b.flush",    {15'd0, b_flush}, {15'd0, e.fb});
      cmp("b.halt",     {15'd0, b_halt},  {15'd0, e.hb});
      cmp("b.cnt",      {12'd0, b_cnt},   e.cb);
      cmp("c.flush",    {15'd0, c_flush}, 16'd0);
      if (e.cchk) cmp("c.cnt", c_cnt, e.cc);
    end
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    reset       = s.rst;
    enable      = s.en;
    id_ex_op    = s.xop;
    id_ex_rt    = s.xrt;
    if_id_op    = s.op;
    if_id_funct = s.fn;
    if_id_rs    = s.rs;
    if_id_rt    = s.rt;
    sb_q.push_back(e);
    @(negedge clk);
    checkOutput();
    row++;
  endtask

  initial begin
    vec_t  tbl[$];
    stim_t s_nop, s_rst, s_ld4, s_rt0, s_addi, s_add9, s_sw, s_jalr;
    stim_t s_ld9, s_nopd, s_ld9d, s_j, s_jal, s_halt;
    stim_t halt_mix[4];
    exp_t  e;

    s_nop  = st(0, 1, OP_ADDI, 5'd0, OP_ADDI,   6'd0,    5'd1,  5'd2);
    s_rst  = st(1, 1, OP_ADDI, 5'd0, OP_ADDI,   6'd0,    5'd1,  5'd2);
    s_ld4  = st(0, 1, OP_LW,   5'd4, OP_R_TYPE, FN_ADD,  5'd4,  5'd5);
    s_rt0  = st(0, 1, OP_LW,   5'd0, OP_R_TYPE, FN_ADD,  5'd0,  5'd0);
    s_addi = st(0, 1, OP_LW,   5'd9, OP_ADDI,   6'd0,    5'd1,  5'd9);
    s_add9 = st(0, 1, OP_LW,   5'd9, OP_R_TYPE, FN_ADD,  5'd1,  5'd9);
    s_sw   = st(0, 1, OP_LH,   5'd7, OP_SW,     6'd0,    5'd2,  5'd7);
    s_jalr = st(0, 1, OP_ADDI, 5'd0, OP_R_TYPE, FN_JALR, 5'd31, 5'd0);
    s_ld9  = st(0, 1, OP_LW,   5'd9, OP_R_TYPE, FN_ADD,  5'd9,  5'd3);
    s_nopd = st(0, 0, OP_ADDI, 5'd0, OP_ADDI,   6'd0,    5'd1,  5'd2);
    s_ld9d = st(0, 0, OP_LW,   5'd9, OP_R_TYPE, FN_ADD,  5'd9,  5'd3);
    s_j    = st(0, 1, OP_ADDI, 5'd0, OP_J,      6'd0,    5'd0,  5'd0);
    s_jal  = st(0, 1, OP_ADDI, 5'd0, OP_JAL,    6'd0,    5'd0,  5'd0);
    s_halt = st(0, 1, OP_LW,   5'd4, OP_HALT,   6'd0,    5'd4,  5'd0);

    e = ex(0, 0, 0, 0, 0, 0, 0, 0);
    e.chk = 1'b0;
    tbl.push_back('{s_rst,  e});
    tbl.push_back('{s_rst,  ex(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 0, 0, 0, 0, 0)});
    // Load-use on rs: one stall cycle for A, three for B.
    tbl.push_back('{s_ld4,  ex(1, 0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 1, 1, 0, 0, 1)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 1, 1, 0, 0, 2)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 1, 0, 0, 0, 3)});
    tbl.push_back('{s_rt0,  ex(0, 0, 0, 1, 0, 0, 0, 3)});
    tbl.push_back('{s_addi, ex(0, 0, 0, 1, 0, 0, 0, 3)});
    tbl.push_back('{s_add9, ex(1, 0, 0, 1, 1, 0, 0, 3)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 2, 1, 0, 0, 4)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 2, 1, 0, 0, 5)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 2, 0, 0, 0, 6)});
    tbl.push_back('{s_sw,   ex(1, 0, 0, 2, 1, 0, 0, 6)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 3, 1, 0, 0, 7)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 3, 1, 0, 0, 8)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 3, 0, 0, 0, 9)});
    tbl.push_back('{s_jalr, ex(0, 1, 0, 3, 0, 1, 0, 9)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 4, 0, 1, 0, 10)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 4, 0, 0, 0, 11)});
    // Enable drops in the middle of B's three-cycle load stall.
    tbl.push_back('{s_ld9,  ex(1, 0, 0, 4, 1, 0, 0, 11)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 5, 1, 0, 0, 12)});
    tbl.push_back('{s_nopd, ex(0, 0, 0, 5, 1, 0, 0, 13)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 5, 1, 0, 0, 13)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 5, 0, 0, 0, 14)});
    tbl.push_back('{s_ld9d, ex(1, 0, 0, 5, 1, 0, 0, 14)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 5, 0, 0, 0, 14)});
    // B's 4-bit counter reaches 15 and saturates; then reset lands mid-JMP.
    tbl.push_back('{s_j,    ex(0, 1, 0, 5, 0, 1, 0, 14)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 6, 0, 1, 0, 15)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 6, 0, 0, 0, 15)});
    tbl.push_back('{s_jal,  ex(0, 1, 0, 6, 0, 1, 0, 15)});
    tbl.push_back('{s_rst,  ex(0, 0, 0, 7, 0, 0, 0, 15)});
    tbl.push_back('{s_nop,  ex(0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{s_halt, ex(1, 0, 1, 0, 1, 0, 1, 0)});
    tbl.push_back('{s_nop,  ex(1, 0, 1, 1, 1, 0, 1, 1)});

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].s, tbl[i].e);
    end

    // HALT is terminal: hazards of every kind are ignored for 20 cycles.
    halt_mix[0] = s_ld9;
    halt_mix[1] = s_jalr;
    halt_mix[2] = s_nop;
    halt_mix[3] = s_j;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(halt_mix[i % 4], ex(1, 0, 1, 1, 1, 0, 1, 1));
    end
    applyStimulus(s_rst, ex(0, 0, 0, 1, 0, 0, 0, 1));
    applyStimulus(s_nop, ex(0, 0, 0, 0, 0, 0, 0, 0));

    // With JMP_BUBBLES=0, C never flushes and only load stalls reach its count.
    e = ex(0, 1, 0, 0, 0, 1, 0, 0); e.cchk = 1'b1; e.cc = 16'd0;
    applyStimulus(s_j, e);
    e = ex(0, 1, 0, 1, 0, 1, 0, 1); e.cchk = 1'b1; e.cc = 16'd0;
    applyStimulus(s_j, e);
    e = ex(0, 0, 0, 2, 0, 0, 0, 2); e.cchk = 1'b1; e.cc = 16'd0;
    applyStimulus(s_nop, e);
    e = ex(1, 0, 0, 2, 1, 0, 0, 2); e.cchk = 1'b1; e.cc = 16'd0;
    applyStimulus(s_ld4, e);
    e = ex(0, 0, 0, 3, 1, 0, 0, 3); e.cchk = 1'b1; e.cc = 16'd1;
    applyStimulus(s_nop, e);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
